// File: rtl/clkout_divider.sv
// clkout_divider: integer output divider for the VCO clock with a programmable
// duty cycle. Publishes the divided period (ps) and a lock flag for the phase
// shifter. New settings take effect only at period boundaries.
module clkout_divider #(
   parameter int LOCK_CYCLES = 8,
   parameter int DIV_W       = 8
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             PWRDWN,
   input  logic [DIV_W-1:0] divide,
   input  logic [6:0]       duty_cycle,
   input  logic [31:0]      clk_period_1000,
   output logic             clk_div,
   output logic [31:0]      clk_div_period_1000,
   output logic             locked
);

   localparam int PW = DIV_W + 8;
   localparam int QW = DIV_W + 32;
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [1:0] {OFF, HIGH, LOW} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] cnt, div_r, high_r;
   logic [DIV_W-1:0] div_eff, high_eff;
   logic [LW-1:0]    lock_cnt;
   logic             clk_div_r, clk_div_nxt;
   logic             run, run_nxt;
   logic             locked_r, locked_nxt;
   logic             reload, boundary, cfg_same;
   logic [PW-1:0]    high_prod, high_quot;
   logic [QW-1:0]    per_prod;
   logic [31:0]      per_sat;

   // Effective configuration from the live inputs; only captured on reload.
   always_comb begin
      div_eff   = (divide == '0) ? DIV_W'(1) : divide;
      high_prod = PW'(div_eff) * PW'(duty_cycle) + PW'(50);
      high_quot = high_prod / PW'(100);
      if (div_eff == DIV_W'(1)) begin
         high_eff = DIV_W'(1);
      end else if (high_quot == '0) begin
         high_eff = DIV_W'(1);
      end else if (high_quot >= PW'(div_eff)) begin
         high_eff = div_eff - DIV_W'(1);
      end else begin
         high_eff = high_quot[DIV_W-1:0];
      end
      per_prod = QW'(div_eff) * QW'(clk_period_1000);
      per_sat  = (per_prod[QW-1:32] != '0) ? 32'hFFFF_FFFF : per_prod[31:0];
      cfg_same = (div_eff == div_r) && (high_eff == high_r);
   end

   // Next state: high phase, low phase, and reload at every period boundary.
   always_comb begin
      state_nxt   = state;
      clk_div_nxt = clk_div_r;
      run_nxt     = run;
      locked_nxt  = locked_r;
      boundary    = 1'b0;
      reload      = 1'b0;
      case (state)
         OFF: begin
            reload     = 1'b1;
            locked_nxt = 1'b0;
         end
         HIGH: begin
            if (run) begin
               boundary = 1'b1;
            end else if (cnt == high_r) begin
               clk_div_nxt = 1'b0;
               state_nxt   = LOW;
            end
         end
         LOW: begin
            if (cnt == div_r) begin
               boundary = 1'b1;
            end
         end
         default: state_nxt = OFF;
      endcase
      if (boundary) begin
         reload     = 1'b1;
         locked_nxt = cfg_same && (lock_cnt == LW'(LOCK_CYCLES));
      end
      if (reload) begin
         state_nxt   = HIGH;
         clk_div_nxt = 1'b1;
         run_nxt     = (div_eff == DIV_W'(1));
      end
   end

   // Control flops; reset and power-down both force an immediate restart from OFF.
   always_ff @(posedge clk or posedge RST or posedge PWRDWN) begin
      if (RST || PWRDWN) begin
         state     <= OFF;
         clk_div_r <= 1'b0;
         run       <= 1'b0;
         locked_r  <= 1'b0;
      end else begin
         state     <= state_nxt;
         clk_div_r <= clk_div_nxt;
         run       <= run_nxt;
         locked_r  <= locked_nxt;
      end
   end

   // Period counter, captured config and lock counter; frozen while powered down.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt                 <= '0;
         div_r               <= '0;
         high_r              <= '0;
         lock_cnt            <= '0;
         clk_div_period_1000 <= '0;
      end else if (!PWRDWN) begin
         if (reload) begin
            cnt                 <= DIV_W'(1);
            div_r               <= div_eff;
            high_r              <= high_eff;
            clk_div_period_1000 <= per_sat;
            if (boundary && cfg_same) begin
               if (lock_cnt != LW'(LOCK_CYCLES)) begin
                  lock_cnt <= lock_cnt + LW'(1);
               end
            end else begin
               lock_cnt <= '0;
            end
         end else if (state != OFF) begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

   // In bypass the VCO clock is passed straight through; power-down makes outputs undefined.
   always_comb begin
      if (PWRDWN && !RST) begin
         clk_div = 1'bx;
         locked  = 1'bx;
      end else begin
         clk_div = run ? clk : clk_div_r;
         locked  = locked_r;
      end
   end

endmodule
